// File: rtl/com_bus_arb_pkg.sv
// Shared constants, FSM state type and index helpers for the common-bus arbiter.
package com_bus_arb_pkg;

    localparam int CORES   = 4;
    localparam int NUM_REQ = 2 * CORES;
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        OWN_SNP,
        OWN_MEM
    } arb_state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    // Round-robin pointer advance, wrapping at the last requester.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 8,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        int               k;
        logic [IDX_W-1:0] cand;
        valid  = 1'b0;
        winner = '0;
        onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            cand = IDX_W'(k);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
        onehot[winner] = valid;
    end

endmodule

// File: rtl/com_bus_arbiter.sv
// Two-level common-bus arbiter: round-robin primary owner among 8 caches,
// plus one nested snoop-or-memory grant at a time while the bus is owned.
module com_bus_arbiter
    import com_bus_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] Com_Bus_Req_proc,
    input  logic [NUM_REQ-1:0] Com_Bus_Req_snoop,
    input  logic               Mem_snoop_req,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt_proc,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt_snoop,
    output logic               Mem_snoop_gnt,
    output logic [IDX_W-1:0]   Bus_owner,
    output logic               Bus_busy,
    output logic               Protocol_err
);

    arb_state_t         state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_proc_reg, gnt_proc_next;
    logic [NUM_REQ-1:0] gnt_snoop_reg, gnt_snoop_next;
    logic               mem_gnt_reg, mem_gnt_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic               busy_reg, busy_next;
    logic               err_reg, err_next;
    logic [IDX_W-1:0]   proc_ptr_reg, proc_ptr_next;
    logic [IDX_W-1:0]   snp_ptr_reg, snp_ptr_next;

    logic [NUM_REQ-1:0] snoop_elig;
    logic               proc_valid, snp_valid;
    logic [IDX_W-1:0]   proc_winner, snp_winner, snp_holder;
    logic [NUM_REQ-1:0] proc_onehot, snp_onehot;

    // The owner can never be its own snooper; its snoop request is masked out.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_snoop_mask
            assign snoop_elig[gi] = Com_Bus_Req_snoop[gi] && (owner_reg != IDX_W'(gi));
        end
    endgenerate

    rr_picker #(.NUM_REQ(NUM_REQ)) u_proc_pick (
        .req    (Com_Bus_Req_proc),
        .ptr    (proc_ptr_reg),
        .valid  (proc_valid),
        .winner (proc_winner),
        .onehot (proc_onehot)
    );

    rr_picker #(.NUM_REQ(NUM_REQ)) u_snp_pick (
        .req    (snoop_elig),
        .ptr    (snp_ptr_reg),
        .valid  (snp_valid),
        .winner (snp_winner),
        .onehot (snp_onehot)
    );

    assign snp_holder = onehot_to_idx(gnt_snoop_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            gnt_proc_reg  <= '0;
            gnt_snoop_reg <= '0;
            mem_gnt_reg   <= 1'b0;
            owner_reg     <= '0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
            proc_ptr_reg  <= '0;
            snp_ptr_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_proc_reg  <= gnt_proc_next;
            gnt_snoop_reg <= gnt_snoop_next;
            mem_gnt_reg   <= mem_gnt_next;
            owner_reg     <= owner_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
            proc_ptr_reg  <= proc_ptr_next;
            snp_ptr_reg   <= snp_ptr_next;
        end
    end

    // Nested grants take precedence over release; release is only seen from OWN.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (proc_valid) state_next = OWN;
            OWN: begin
                if (snp_valid)                         state_next = OWN_SNP;
                else if (Mem_snoop_req)                state_next = OWN_MEM;
                else if (!Com_Bus_Req_proc[owner_reg]) state_next = IDLE;
            end
            OWN_SNP: if (!Com_Bus_Req_snoop[snp_holder]) state_next = OWN;
            OWN_MEM: if (!Mem_snoop_req)                 state_next = OWN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt_proc_next  = gnt_proc_reg;
        gnt_snoop_next = gnt_snoop_reg;
        mem_gnt_next   = mem_gnt_reg;
        owner_next     = owner_reg;
        busy_next      = busy_reg;
        proc_ptr_next  = proc_ptr_reg;
        snp_ptr_next   = snp_ptr_reg;
        err_next       = err_reg
                       | ((state_reg == IDLE) && ((|Com_Bus_Req_snoop) || Mem_snoop_req))
                       | (busy_reg && Com_Bus_Req_snoop[owner_reg]);
        unique case (state_reg)
            IDLE: begin
                if (proc_valid) begin
                    gnt_proc_next = proc_onehot;
                    owner_next    = proc_winner;
                    busy_next     = 1'b1;
                    proc_ptr_next = next_idx(proc_winner);
                end
            end
            OWN: begin
                if (snp_valid) begin
                    gnt_snoop_next = snp_onehot;
                    snp_ptr_next   = next_idx(snp_winner);
                end else if (Mem_snoop_req) begin
                    mem_gnt_next = 1'b1;
                end else if (!Com_Bus_Req_proc[owner_reg]) begin
                    gnt_proc_next = '0;
                    busy_next     = 1'b0;
                end
            end
            OWN_SNP: if (!Com_Bus_Req_snoop[snp_holder]) gnt_snoop_next = '0;
            OWN_MEM: if (!Mem_snoop_req)                 mem_gnt_next   = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt_proc_reg));
            assert ($onehot0(gnt_snoop_reg));
            assert (!(mem_gnt_reg && (|gnt_snoop_reg)));
        end
    end

    assign Com_Bus_Gnt_proc  = gnt_proc_reg;
    assign Com_Bus_Gnt_snoop = gnt_snoop_reg;
    assign Mem_snoop_gnt     = mem_gnt_reg;
    assign Bus_owner         = owner_reg;
    assign Bus_busy          = busy_reg;
    assign Protocol_err      = err_reg;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Directed test-plan scenarios plus random traffic, checked against a
// transaction-level model of the two-level arbiter.
module tb_com_bus_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_proc, req_snoop;
    logic         mem_req;
    logic [N-1:0] gnt_proc, gnt_snoop;
    logic         mem_gnt;
    logic [2:0]   bus_owner;
    logic         bus_busy, proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner -1 = bus free; nest 0 none, 1 snoop (m_nj), 2 memory.
    int m_owner, m_nest, m_nj, m_pptr, m_sptr;
    bit m_err;

    com_bus_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .Com_Bus_Req_proc  (req_proc),
        .Com_Bus_Req_snoop (req_snoop),
        .Mem_snoop_req     (mem_req),
        .Com_Bus_Gnt_proc  (gnt_proc),
        .Com_Bus_Gnt_snoop (gnt_snoop),
        .Mem_snoop_gnt     (mem_gnt),
        .Bus_owner         (bus_owner),
        .Bus_busy          (bus_busy),
        .Protocol_err      (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner = -1; m_nest = 0; m_nj = 0; m_pptr = 0; m_sptr = 0; m_err = 0;
            return;
        end
        if (m_owner < 0 && (req_snoop != 0 || mem_req)) m_err = 1;
        if (m_owner >= 0 && req_snoop[m_owner]) m_err = 1;
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int k = (m_pptr + i) % N;
                if (req_proc[k]) begin
                    m_owner = k;
                    m_pptr  = (k + 1) % N;
                    break;
                end
            end
        end else if (m_nest == 0) begin
            int found = -1;
            for (int i = 0; i < N; i++) begin
                int k = (m_sptr + i) % N;
                if (k != m_owner && req_snoop[k]) begin
                    found = k;
                    break;
                end
            end
            if (found >= 0) begin
                m_nest = 1; m_nj = found; m_sptr = (found + 1) % N;
            end else if (mem_req) begin
                m_nest = 2;
            end else if (!req_proc[m_owner]) begin
                m_owner = -1;
            end
        end else if (m_nest == 1) begin
            if (!req_snoop[m_nj]) m_nest = 0;
        end else begin
            if (!mem_req) m_nest = 0;
        end
    endtask

    // One clock: inputs already applied; advance model, then compare #1 after the edge.
    task automatic cycle();
        logic [N-1:0] exp_proc, exp_snp;
        model_step();
        @(posedge clk);
        #1;
        exp_proc = '0;
        exp_snp  = '0;
        if (m_owner >= 0) exp_proc[m_owner] = 1'b1;
        if (m_nest == 1)  exp_snp[m_nj] = 1'b1;
        check_eq("gnt_proc", 32'(gnt_proc), 32'(exp_proc));
        check_eq("gnt_snoop", 32'(gnt_snoop), 32'(exp_snp));
        check_eq("mem_gnt", 32'(mem_gnt), 32'(m_nest == 2));
        check_eq("bus_busy", 32'(bus_busy), 32'(m_owner >= 0));
        if (m_owner >= 0) check_eq("bus_owner", 32'(bus_owner), 32'(m_owner));
        check_eq("protocol_err", 32'(proto_err), 32'(m_err));
        check_eq("nested_excl", 32'(mem_gnt && (gnt_snoop != 0)), 32'(0));
    endtask

    task automatic drive(input logic r, input logic [N-1:0] p, input logic [N-1:0] s,
                         input logic m, input int cycles);
        rst = r; req_proc = p; req_snoop = s; mem_req = m;
        for (int c = 0; c < cycles; c++) cycle();
    endtask

    initial begin
        int order[8];
        int n_ord;
        int age;
        logic prev_busy;
        logic [N-1:0] rr_req;

        rst = 1'b1; req_proc = '0; req_snoop = '0; mem_req = 1'b0;
        m_owner = -1; m_nest = 0; m_nj = 0; m_pptr = 0; m_sptr = 0; m_err = 0;

        // Reset state and single request with release.
        drive(1, 8'h00, 8'h00, 0, 2);
        drive(0, 8'h04, 8'h00, 0, 4);
        drive(0, 8'h00, 8'h00, 0, 2);

        // Round-robin 0,3,5, with req 0 re-raised while 3 and 5 pend.
        drive(1, 8'h00, 8'h00, 0, 1);
        rst = 0;
        rr_req = 8'b0010_1001;
        n_ord = 0; age = 0; prev_busy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            req_proc = rr_req;
            cycle();
            if (bus_busy && !prev_busy) begin
                if (n_ord < 8) order[n_ord] = int'(bus_owner);
                n_ord++;
                age = 0;
                if (n_ord == 2) rr_req[0] = 1'b1;
            end else if (bus_busy) begin
                age++;
            end
            if (bus_busy && age == 1) rr_req[bus_owner] = 1'b0;
            prev_busy = bus_busy;
        end
        check_eq("rr_count", 32'(n_ord), 32'd4);
        check_eq("rr_order0", 32'(order[0]), 32'd0);
        check_eq("rr_order1", 32'(order[1]), 32'd3);
        check_eq("rr_order2", 32'(order[2]), 32'd5);
        check_eq("rr_order3", 32'(order[3]), 32'd0);

        // Nested snoop held across proc release.
        drive(1, 8'h00, 8'h00, 0, 1);
        drive(0, 8'h02, 8'h00, 0, 2);
        drive(0, 8'h02, 8'h10, 0, 2);
        drive(0, 8'h00, 8'h10, 0, 3);
        drive(0, 8'h00, 8'h00, 0, 3);

        // Snoop beats memory, memory follows.
        drive(1, 8'h00, 8'h00, 0, 1);
        drive(0, 8'h01, 8'h00, 0, 2);
        drive(0, 8'h01, 8'h40, 1, 3);
        drive(0, 8'h01, 8'h00, 1, 3);
        drive(0, 8'h00, 8'h00, 0, 3);

        // Protocol errors: snoop with no owner, owner snooping itself.
        drive(1, 8'h00, 8'h00, 0, 1);
        drive(0, 8'h00, 8'h08, 0, 2);
        drive(0, 8'h04, 8'h00, 0, 2);
        drive(0, 8'h04, 8'h04, 0, 3);
        drive(0, 8'h00, 8'h00, 0, 3);

        // Reset during OWN_SNP, then pointer restarts at 0.
        drive(1, 8'h00, 8'h00, 0, 1);
        drive(0, 8'h02, 8'h00, 0, 2);
        drive(0, 8'h02, 8'h10, 0, 2);
        drive(1, 8'h02, 8'h10, 0, 1);
        drive(0, 8'h81, 8'h00, 0, 3);
        drive(0, 8'h80, 8'h00, 0, 3);
        drive(0, 8'h00, 8'h00, 0, 2);

        // Random traffic with held requests.
        drive(1, 8'h00, 8'h00, 0, 1);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0)  req_proc[b]  = ~req_proc[b];
                if ($urandom_range(0, 15) == 0) req_snoop[b] = ~req_snoop[b];
            end
            if ($urandom_range(0, 11) == 0) mem_req = ~mem_req;
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
